pru_cmd_sequencer: RTL and testbench

//  Memory-mapped front end directly upstream of the PRU draw engine. Decodes CPU bus writes into

---
 rtl/pru_pkg.sv | 32 +++
 rtl/pru_cmd_fifo.sv | 56 +++++
 rtl/pru_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pru_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pru_pkg.sv
// rtl/pru_pkg.sv - shared types and register offsets for the PRU command sequencer
package pru_pkg;

  // One committed draw command: CMD fields plus the staging snapshot
  typedef struct packed {
    logic [1:0]  shape;
    logic [1:0]  color;
    logic        subtract;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [9:0]  width;
    logic [8:0]  hr;
    logic [31:0] bmap;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } seq_state_t;

  // Byte offsets from the register window base
  localparam logic [31:0] OFF_GEOM   = 32'h00;
  localparam logic [31:0] OFF_SIZE   = 32'h04;
  localparam logic [31:0] OFF_CMD    = 32'h08;
  localparam logic [31:0] OFF_PAL_LO = 32'h0C;
  localparam logic [31:0] OFF_PAL_HI = 32'h18;
  localparam logic [31:0] OFF_BMAP   = 32'h1C;
  localparam logic [31:0] OFF_STATUS = 32'h20;

endpackage

// File: rtl/pru_cmd_fifo.sv
// rtl/pru_cmd_fifo.sv - synchronous FIFO of draw commands with push-while-full-and-pop support
module pru_cmd_fifo
  import pru_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  cmd_t                       i_push_data,
  input  logic                       i_pop,
  output cmd_t                       o_rd_data,
  output logic                       o_push_ok,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_count;
  logic          w_pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_count   = w_count;
  assign o_full    = (w_count == PW'(DEPTH));
  assign o_empty   = (w_count == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push is about to fill
  assign o_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Entry storage; no reset needed since reads are gated by the pointers
  always_ff @(posedge i_clk) begin
    if (o_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  // Read and write pointer advance
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pru_cmd_sequencer.sv
// rtl/pru_cmd_sequencer.sv - CPU register front end and command issue FSM for the PRU draw engine
module pru_cmd_sequencer
  import pru_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h40000100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_we,
  input  logic        i_bus_re,
  input  logic [31:0] i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic [31:0] o_bus_rdata,
  output logic        o_pru_start,
  output logic [1:0]  o_pru_shape_select,
  output logic [9:0]  o_pru_col,
  output logic [8:0]  o_pru_row,
  output logic [9:0]  o_pru_width,
  output logic [8:0]  o_pru_height_radius,
  output logic [1:0]  o_pru_color,
  output logic        o_pru_subtract,
  output logic [31:0] o_pru_bitmap_addr,
  output logic        o_pru_color_load,
  output logic [31:0] o_pru_addr,
  output logic [31:0] o_pru_data,
  input  logic        i_pru_busy,
  input  logic        i_pru_done,
  output logic        o_irq_idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   w_off;
  logic          w_wr_geom, w_wr_size, w_wr_cmd, w_wr_pal, w_wr_bmap, w_wr_stat;
  logic          w_rd_stat;
  cmd_t          w_push_data;
  cmd_t          w_head;
  logic          w_push_ok, w_full, w_empty, w_pop;
  logic [CW-1:0] w_count;
  logic [3:0]    w_cnt4;
  logic [31:0]   w_status;

  logic [9:0]    r_col;
  logic [8:0]    r_row;
  logic [9:0]    r_width;
  logic [8:0]    r_hr;
  logic [31:0]   r_bmap;
  logic          r_overflow;
  seq_state_t    r_state;

  // Address decode relative to the register window
  assign w_off     = i_bus_addr - BASE_ADDR;
  assign w_wr_geom = i_bus_we && (w_off == OFF_GEOM);
  assign w_wr_size = i_bus_we && (w_off == OFF_SIZE);
  assign w_wr_cmd  = i_bus_we && (w_off == OFF_CMD);
  assign w_wr_bmap = i_bus_we && (w_off == OFF_BMAP);
  assign w_wr_stat = i_bus_we && (w_off == OFF_STATUS);
  assign w_rd_stat = i_bus_re && (w_off == OFF_STATUS);
  assign w_wr_pal  = i_bus_we && (w_off >= OFF_PAL_LO) && (w_off <= OFF_PAL_HI) &&
                     (w_off[1:0] == 2'b00);

  // Snapshot of staging registers plus the CMD write fields
  always_comb begin
    w_push_data          = '0;
    w_push_data.shape    = i_bus_wdata[1:0];
    w_push_data.color    = i_bus_wdata[5:4];
    w_push_data.subtract = i_bus_wdata[8];
    w_push_data.col      = r_col;
    w_push_data.row      = r_row;
    w_push_data.width    = r_width;
    w_push_data.hr       = r_hr;
    w_push_data.bmap     = r_bmap;
  end

  assign w_pop = (r_state == S_IDLE) && !w_empty && !i_pru_busy && !i_pru_done;

  pru_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_wr_cmd),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_rd_data   (w_head),
    .o_push_ok   (w_push_ok),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign w_cnt4   = 4'(w_count);
  assign w_status = {24'd0, w_cnt4, r_overflow, (r_state != S_IDLE), w_full, w_empty};

  // Staging registers; they survive a commit so repeated draws only rewrite what changes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_width <= '0;
      r_hr    <= '0;
      r_bmap  <= '0;
    end else begin
      if (w_wr_geom) begin
        r_col <= i_bus_wdata[9:0];
        r_row <= i_bus_wdata[24:16];
      end
      if (w_wr_size) begin
        r_width <= i_bus_wdata[9:0];
        r_hr    <= i_bus_wdata[24:16];
      end
      if (w_wr_bmap) r_bmap <= i_bus_wdata;
    end
  end

  // Sticky overflow on a dropped push; a new drop beats a same-cycle clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_wr_cmd && !w_push_ok) begin
      r_overflow <= 1'b1;
    end else if (w_wr_stat && i_bus_wdata[3]) begin
      r_overflow <= 1'b0;
    end
  end

  // Read data and palette forwarding, both registered one cycle after the bus strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_rdata      <= '0;
      o_pru_color_load <= 1'b0;
      o_pru_addr       <= '0;
      o_pru_data       <= '0;
    end else begin
      o_bus_rdata      <= w_rd_stat ? w_status : 32'd0;
      o_pru_color_load <= w_wr_pal;
      if (w_wr_pal) begin
        o_pru_addr <= i_bus_addr;
        o_pru_data <= i_bus_wdata;
      end
    end
  end

  // Issue FSM: pop and latch params, raise start, wait for done, then wait for PRU to settle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state             <= S_IDLE;
      o_pru_start         <= 1'b0;
      o_pru_shape_select  <= '0;
      o_pru_col           <= '0;
      o_pru_row           <= '0;
      o_pru_width         <= '0;
      o_pru_height_radius <= '0;
      o_pru_color         <= '0;
      o_pru_subtract      <= 1'b0;
      o_pru_bitmap_addr   <= '0;
      o_irq_idle          <= 1'b0;
    end else begin
      o_irq_idle <= w_empty && (r_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            o_pru_shape_select  <= w_head.shape;
            o_pru_col           <= w_head.col;
            o_pru_row           <= w_head.row;
            o_pru_width         <= w_head.width;
            o_pru_height_radius <= w_head.hr;
            o_pru_color         <= w_head.color;
            o_pru_subtract      <= w_head.subtract;
            o_pru_bitmap_addr   <= w_head.bmap;
            o_pru_start         <= 1'b1;
            r_state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_pru_done) begin
            o_pru_start <= 1'b0;
            r_state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!i_pru_done && !i_pru_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pru_cmd_sequencer.sv
// tb/tb_pru_cmd_sequencer.sv - directed self-checking bench for pru_cmd_sequencer
module tb_pru_cmd_sequencer;

  localparam logic [31:0] BASE = 32'h40000100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        pru_start;
  logic [1:0]  pru_shape_select;
  logic [9:0]  pru_col;
  logic [8:0]  pru_row;
  logic [9:0]  pru_width;
  logic [8:0]  pru_height_radius;
  logic [1:0]  pru_color;
  logic        pru_subtract;
  logic [31:0] pru_bitmap_addr;
  logic        pru_color_load;
  logic [31:0] pru_addr;
  logic [31:0] pru_data;
  logic        pru_busy = 1'b0;
  logic        pru_done = 1'b0;
  logic        irq_idle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pru_cmd_sequencer #(.DEPTH(8), .BASE_ADDR(BASE)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_bus_we            (bus_we),
    .i_bus_re            (bus_re),
    .i_bus_addr          (bus_addr),
    .i_bus_wdata         (bus_wdata),
    .o_bus_rdata         (bus_rdata),
    .o_pru_start         (pru_start),
    .o_pru_shape_select  (pru_shape_select),
    .o_pru_col           (pru_col),
    .o_pru_row           (pru_row),
    .o_pru_width         (pru_width),
    .o_pru_height_radius (pru_height_radius),
    .o_pru_color         (pru_color),
    .o_pru_subtract      (pru_subtract),
    .o_pru_bitmap_addr   (pru_bitmap_addr),
    .o_pru_color_load    (pru_color_load),
    .o_pru_addr          (pru_addr),
    .o_pru_data          (pru_data),
    .i_pru_busy          (pru_busy),
    .i_pru_done          (pru_done),
    .o_irq_idle          (irq_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_re   = 1'b1;
    bus_addr = a;
    tick();
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  logic [31:0] rv;
  int          exp_col [9];
  int          exp_clr [9];

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_start", 32'(pru_start), 32'd0);
    chk("rst_irq", 32'(irq_idle), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_irq", 32'(irq_idle), 32'd1);
    rd(BASE + 32'h20, rv);
    chk("post_rst_status", rv, 32'h01);

    // 1) basic command and N+2 latency
    wr(BASE + 32'h00, 32'h0014_000A);
    wr(BASE + 32'h04, 32'h0008_0010);
    wr(BASE + 32'h08, 32'h11);
    chk("t1_start_n1", 32'(pru_start), 32'd0);
    tick();
    chk("t1_start_n2", 32'(pru_start), 32'd1);
    chk("t1_col", 32'(pru_col), 32'd10);
    chk("t1_row", 32'(pru_row), 32'd20);
    chk("t1_width", 32'(pru_width), 32'd16);
    chk("t1_hr", 32'(pru_height_radius), 32'd8);
    chk("t1_color", 32'(pru_color), 32'd1);
    chk("t1_shape", 32'(pru_shape_select), 32'd1);
    chk("t1_sub", 32'(pru_subtract), 32'd0);

    // 2) long draw: start and params held until done
    pru_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t2_hold_start", 32'(pru_start), 32'd1);
      chk("t2_hold_col", 32'(pru_col), 32'd10);
    end
    rd(BASE + 32'h20, rv);
    chk("t2_status_busy", rv, 32'h05);
    pru_done = 1'b1;
    pru_busy = 1'b0;
    tick();
    chk("t2_start_drop", 32'(pru_start), 32'd0);
    chk("t2_col_held", 32'(pru_col), 32'd10);
    pru_done = 1'b0;
    tick();
    tick();
    chk("t2_irq_idle", 32'(irq_idle), 32'd1);

    // 3) nine commits while PRU busy: eight queued, ninth dropped
    pru_busy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wr(BASE + 32'h00, 32'h0014_0000 | 32'(100 + k));
      wr(BASE + 32'h08, 32'((k & 3) << 4) | 32'(k & 1));
    end
    chk("t3_no_start", 32'(pru_start), 32'd0);
    rd(BASE + 32'h20, rv);
    chk("t3_status_full_ovf", rv, 32'h8A);
    wr(BASE + 32'h20, 32'h8);
    rd(BASE + 32'h20, rv);
    chk("t3_status_ovf_clr", rv, 32'h82);

    // 6) full FIFO: pop and commit in the same cycle
    wr(BASE + 32'h00, 32'h0014_00C8);
    pru_busy = 1'b0;
    wr(BASE + 32'h08, 32'h32);
    chk("t6_start", 32'(pru_start), 32'd1);
    pru_busy = 1'b1;
    rd(BASE + 32'h20, rv);
    chk("t6_status", rv, 32'h86);

    // 3 cont.) drain in order; the entry from step 6 comes last
    for (int k = 0; k < 8; k++) begin
      exp_col[k] = 100 + k;
      exp_clr[k] = k & 3;
    end
    exp_col[8] = 200;
    exp_clr[8] = 3;
    for (int k = 0; k < 9; k++) begin
      chk("drain_start", 32'(pru_start), 32'd1);
      chk("drain_col", 32'(pru_col), 32'(exp_col[k]));
      chk("drain_color", 32'(pru_color), 32'(exp_clr[k]));
      tick();
      pru_done = 1'b1;
      tick();
      chk("drain_release", 32'(pru_start), 32'd0);
      pru_done = 1'b0;
      pru_busy = 1'b0;
      tick();
      tick();
    end
    tick();
    chk("drain_irq_idle", 32'(irq_idle), 32'd1);
    rd(BASE + 32'h20, rv);
    chk("drain_status", rv, 32'h01);

    // 4) palette write forwarded, FIFO untouched
    wr(BASE + 32'h0C, 32'h3FF);
    chk("t4_load", 32'(pru_color_load), 32'd1);
    chk("t4_addr", pru_addr, 32'h4000010C);
    chk("t4_data", pru_data, 32'h3FF);
    tick();
    chk("t4_load_pulse", 32'(pru_color_load), 32'd0);
    rd(BASE + 32'h20, rv);
    chk("t4_status", rv, 32'h01);

    // Unmapped write ignored, non-STATUS read returns zero
    wr(BASE + 32'h24, 32'h11);
    tick();
    chk("unmapped_start", 32'(pru_start), 32'd0);
    rd(BASE + 32'h00, rv);
    chk("geom_read_zero", rv, 32'h0);

    // 5) reset mid-draw
    wr(BASE + 32'h08, 32'h2);
    tick();
    chk("t5_start", 32'(pru_start), 32'd1);
    tick();
    pru_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_start_async", 32'(pru_start), 32'd0);
    chk("t5_col_async", 32'(pru_col), 32'd0);
    chk("t5_shape_async", 32'(pru_shape_select), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    pru_busy = 1'b0;
    tick();
    tick();
    chk("t5_irq_idle", 32'(irq_idle), 32'd1);
    rd(BASE + 32'h20, rv);
    chk("t5_status", rv, 32'h01);

    // Staging cleared by reset: a bare commit draws at the origin
    wr(BASE + 32'h08, 32'h0);
    tick();
    chk("t5_stage_start", 32'(pru_start), 32'd1);
    chk("t5_stage_col", 32'(pru_col), 32'd0);
    chk("t5_stage_row", 32'(pru_row), 32'd0);
    chk("t5_stage_width", 32'(pru_width), 32'd0);
    tick();
    pru_done = 1'b1;
    tick();
    pru_done = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
